// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control unit: operator codes, FSM states,
// and the decimal digit accumulation helper.
package calc_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  localparam int MAX_DIGITS_DEF = 3;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // Appends one decimal digit, wrapping modulo 256.
  function automatic logic [7:0] acc_digit(input logic [7:0] cur, input logic [3:0] d);
    logic [15:0] t;
    t = (16'(cur) * 16'd10) + 16'(d);
    return t[7:0];
  endfunction

endpackage

// File: rtl/cu_if.sv
// Keypad-to-control-unit bus: key codes and levels in, display value and digit count out.
interface cu_if;
  logic [3:0] num;
  logic       numPressed;
  logic [2:0] opt;
  logic       optPressed;
  logic       submit;
  logic [7:0] byteNum;
  logic [1:0] nTimes;

  modport master (
    output num, numPressed, opt, optPressed, submit,
    input  byteNum, nTimes
  );

  modport slave (
    input  num, numPressed, opt, optPressed, submit,
    output byteNum, nTimes
  );
endinterface

// File: rtl/cu_alu.sv
// Combinational 8-bit unsigned ALU; division by zero yields 255, modulo by zero yields A.
module cu_alu
  import calc_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] res_o
);

  logic [15:0] prod;
  assign prod = 16'(a_i) * 16'(b_i);

  always_comb begin
    res_o = a_i + b_i;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_MUL:  res_o = prod[7:0];
      OP_DIV:  res_o = (b_i == 8'd0) ? 8'hFF : (a_i / b_i);
      OP_MOD:  res_o = (b_i == 8'd0) ? a_i : (a_i % b_i);
      default: res_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/cu.sv
// Calculator control unit: key edge detection, operand digit entry, operator latching
// and evaluation FSM (ENTER_A -> ENTER_B -> RESULT).
module cu
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic clk,
  input  logic reset,
  cu_if.slave  bus
);

  state_t     state_q;
  logic [7:0] a_q, b_q, byte_q;
  logic [2:0] op_q;
  logic [1:0] ntimes_q;
  logic       num_prev_q, opt_prev_q, sub_prev_q;

  logic       num_press, opt_press, sub_press, digit_ok, room_ok;
  logic [7:0] cur_d, alu_res;

  assign num_press = bus.numPressed & ~num_prev_q;
  assign opt_press = bus.optPressed & ~opt_prev_q;
  assign sub_press = bus.submit     & ~sub_prev_q;
  assign digit_ok  = (bus.num <= 4'd9);
  assign room_ok   = (32'(ntimes_q) < MAX_DIGITS);
  assign cur_d     = acc_digit((state_q == ENTER_B) ? b_q : a_q, bus.num);

  cu_alu u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .res_o(alu_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ENTER_A;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      op_q       <= OP_ADD;
      byte_q     <= 8'd0;
      ntimes_q   <= 2'd0;
      // Treat keys as already held so one held through reset is not seen as a press.
      num_prev_q <= 1'b1;
      opt_prev_q <= 1'b1;
      sub_prev_q <= 1'b1;
    end else begin
      num_prev_q <= bus.numPressed;
      opt_prev_q <= bus.optPressed;
      sub_prev_q <= bus.submit;

      if (sub_press) begin
        if (state_q == ENTER_B && ntimes_q != 2'd0) begin
          a_q      <= alu_res;
          byte_q   <= alu_res;
          ntimes_q <= 2'd0;
          state_q  <= RESULT;
        end
      end else if (opt_press) begin
        if (bus.opt >= OP_CLEAR) begin
          state_q  <= ENTER_A;
          a_q      <= 8'd0;
          b_q      <= 8'd0;
          op_q     <= OP_ADD;
          byte_q   <= 8'd0;
          ntimes_q <= 2'd0;
        end else begin
          op_q     <= bus.opt;
          b_q      <= 8'd0;
          ntimes_q <= 2'd0;
          state_q  <= ENTER_B;
          // In ENTER_B a pending operand chains into A before the new operator.
          if (state_q == ENTER_B && ntimes_q != 2'd0) begin
            a_q    <= alu_res;
            byte_q <= alu_res;
          end else begin
            byte_q <= a_q;
          end
        end
      end else if (num_press && digit_ok) begin
        case (state_q)
          ENTER_A: if (room_ok) begin
            a_q      <= cur_d;
            byte_q   <= cur_d;
            ntimes_q <= ntimes_q + 2'd1;
          end
          ENTER_B: if (room_ok) begin
            b_q      <= cur_d;
            byte_q   <= cur_d;
            ntimes_q <= ntimes_q + 2'd1;
          end
          RESULT: begin
            a_q      <= {4'd0, bus.num};
            byte_q   <= {4'd0, bus.num};
            ntimes_q <= 2'd1;
            state_q  <= ENTER_A;
          end
          default: state_q <= ENTER_A;
        endcase
      end

      if (!(state_q inside {ENTER_A, ENTER_B, RESULT})) state_q <= ENTER_A;
    end
  end

  assign bus.byteNum = byte_q;
  assign bus.nTimes  = ntimes_q;

endmodule

// File: tb/tb_cu.sv
// Self-checking bench for cu: table of key presses with expected display values,
// plus hand sequences for hold, invalid digit, simultaneous presses and async reset.
module tb_cu;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cu_if bus ();

  cu #(.MAX_DIGITS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int         kind;   // 0 digit, 1 operator, 2 submit
    logic [3:0] val;
    logic [7:0] eb;
    logic [1:0] en;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] eb;
    logic [1:0] en;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input int k, input int v, input int b, input int n);
    vec_t x;
    x.kind = k; x.val = 4'(v); x.eb = 8'(b); x.en = 2'(n);
    vecs.push_back(x);
  endfunction

  task automatic cmp(input string name, input logic [7:0] eb, input logic [1:0] en);
    total++;
    if (bus.byteNum !== eb || bus.nTimes !== en) begin
      bad++;
      $display("FAIL %s: byteNum=%0d nTimes=%0d, required byteNum=%0d nTimes=%0d",
               name, bus.byteNum, bus.nTimes, eb, en);
    end else begin
      $display("txn %s: byteNum=%0d nTimes=%0d", name, bus.byteNum, bus.nTimes);
    end
  endtask

  // One press of any combination of keys, one cycle high then released.
  task automatic press(input bit dn, input logic [3:0] nv, input bit dop, input logic [2:0] ov,
                       input bit ds, input logic [7:0] eb, input logic [1:0] en,
                       input string name);
    exp_t e;
    @(negedge clk);
    bus.num = nv; bus.opt = ov;
    bus.numPressed = dn; bus.optPressed = dop; bus.submit = ds;
    e.name = name; e.eb = eb; e.en = en;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, required one entry", name);
    end else begin
      e = sb.pop_front();
      cmp(e.name, e.eb, e.en);
    end
    @(negedge clk);
    bus.numPressed = 1'b0; bus.optPressed = 1'b0; bus.submit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.num = 4'd0; bus.opt = 3'd0;
    bus.numPressed = 1'b0; bus.optPressed = 1'b0; bus.submit = 1'b0;

    // Reset state and release
    #3 cmp("reset_async", 8'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1 cmp("reset_held", 8'd0, 2'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 cmp("reset_release", 8'd0, 2'd0);

    // Digit entry
    add(0,2,2,1); add(0,3,23,2); add(0,1,231,3);
    // Saturation and wrap
    add(1,5,0,0); add(0,1,1,1); add(0,2,12,2); add(0,3,123,3); add(0,4,123,3);
    add(1,5,0,0); add(0,9,9,1); add(0,9,99,2); add(0,9,231,3);
    // 12 + 30, then result * 10
    add(1,5,0,0); add(0,1,1,1); add(0,2,12,2); add(1,0,12,0); add(0,3,3,1); add(0,0,30,2);
    add(2,0,42,0); add(1,2,42,0); add(0,1,1,1); add(0,0,10,2); add(2,0,164,0);
    // SUB wrap, DIV by 0, MOD by 0
    add(1,5,0,0); add(0,5,5,1); add(1,1,5,0); add(0,7,7,1); add(2,0,254,0);
    add(0,9,9,1); add(1,3,9,0); add(0,0,0,1); add(2,0,255,0);
    add(0,9,9,1); add(1,4,9,0); add(0,0,0,1); add(2,0,9,0);
    // Chained operator, submit with empty B, submit in RESULT
    add(1,5,0,0); add(0,2,2,1); add(1,0,2,0); add(0,3,3,1); add(1,1,5,0); add(2,0,5,0);
    add(0,1,1,1); add(2,0,4,0); add(2,0,4,0);
    // Submit in ENTER_A ignored; CLEAR code 7
    add(1,5,0,0); add(0,7,7,1); add(2,0,7,1); add(1,7,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].kind == 0, vecs[i].val, vecs[i].kind == 1, vecs[i].val[2:0],
            vecs[i].kind == 2, vecs[i].eb, vecs[i].en, $sformatf("vec%0d", i));
    end

    // Simultaneous presses: submit beats opt and num; opt beats num
    press(1,4'd6,0,3'd0,0, 8'd6,2'd1, "prio_setup_a");
    press(0,4'd0,1,OP_ADD,0, 8'd6,2'd0, "prio_setup_op");
    press(1,4'd2,0,3'd0,0, 8'd2,2'd1, "prio_setup_b");
    press(1,4'd3,1,OP_MUL,1, 8'd8,2'd0, "prio_submit_wins");
    press(1,4'd4,1,OP_SUB,0, 8'd8,2'd0, "prio_opt_wins");
    press(1,4'd4,0,3'd0,0, 8'd4,2'd1, "prio_after_b");
    press(0,4'd0,0,3'd0,1, 8'd4,2'd0, "prio_sub_result");

    // Held digit key gives a single press
    press(0,4'd0,1,OP_CLEAR,0, 8'd0,2'd0, "hold_clear");
    @(negedge clk);
    bus.num = 4'd5; bus.numPressed = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 cmp($sformatf("hold_cycle%0d", c), 8'd5, 2'd1);
    end
    @(negedge clk) bus.numPressed = 1'b0;

    // Invalid digit code ignored
    press(1,4'd12,0,3'd0,0, 8'd5,2'd1, "digit_12_ignored");

    // Async reset mid-entry
    press(1,4'd4,0,3'd0,0, 8'd54,2'd2, "pre_reset_digit");
    @(negedge clk);
    #2 reset = 1'b0;
    #1 cmp("reset_mid_entry", 8'd0, 2'd0);
    @(negedge clk) reset = 1'b1;
    press(1,4'd8,0,3'd0,0, 8'd8,2'd1, "post_reset_digit");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
